spi_master: RTL and testbench

Parametrised SPI master, successor to the fixed 8-bit, mode-0 SPI link between the SoC and external memory. Adds:
- configurable word width
- runtime clock divider
- all four CPOL/CPHA modes
- multiple active-low chip selects
- start/busy/done handshake

It sits between the SoC bus-side register logic and the chip pins (spi_clk, spi_mosi, spi_miso, chip selects).

---
 rtl/spi_master.sv | 160 ++++++++++++++++
 tb/tb_spi_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master: configurable word width, runtime clock divider, all four
// CPOL/CPHA modes and several active-low chip selects. A transfer is a fixed
// sequence SETUP -> XFER -> HOLD, each phase built from half-periods of
// clk_div+1 system clocks. All pin-facing outputs come straight from flops.
module spi_master #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int NUM_CS = 2,
  parameter int CS_W   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  // Half-period index runs 0 (setup) .. 2*DATA_W (last half-period of XFER).
  localparam int              HALF_W    = $clog2(2 * DATA_W + 1);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DATA_W);

  logic [1:0]        state_reg;
  logic [DIV_W-1:0]  div_reg;
  logic [DIV_W-1:0]  cnt_reg;
  logic [HALF_W-1:0] half_reg;
  logic              cpol_reg;
  logic              cpha_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic [NUM_CS-1:0] cs_dec;

  logic              period_end;
  logic [HALF_W-1:0] next_half;
  logic              next_leading;
  logic              present_bit;
  logic              sample_bit;

  // One-hot chip-select decode; an out-of-range index selects nothing.
  generate
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
      assign cs_dec[gi] = (cs_sel == CS_W'(gi));
    end
  endgenerate

  // Decode what the upcoming serial-clock edge must do. Odd edges are
  // leading, even edges trailing; in mode cpha=0 the final trailing edge
  // shifts nothing out because the last bit must stay on the line.
  always_comb begin
    period_end   = (cnt_reg == div_reg);
    next_half    = half_reg + 1'b1;
    next_leading = next_half[0];
    present_bit  = 1'b0;
    sample_bit   = 1'b0;
    if (cpha_reg) begin
      present_bit = next_leading;
      sample_bit  = !next_leading;
    end else begin
      present_bit = !next_leading && (next_half != LAST_HALF);
      sample_bit  = next_leading;
    end
  end

  // Transfer sequencer: latches the request, paces half-periods, drives the
  // pins and shifts data in and out MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      cnt_reg      <= '0;
      half_reg     <= '0;
      cpol_reg     <= 1'b0;
      cpha_reg     <= 1'b0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rx_data      <= '0;
      spi_clk      <= 1'b0;
      spi_mosi     <= 1'b0;
      spi_cs_n     <= '1;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= SETUP;
            busy      <= 1'b1;
            div_reg   <= clk_div;
            cpol_reg  <= cpol;
            cpha_reg  <= cpha;
            cnt_reg   <= '0;
            half_reg  <= '0;
            spi_clk   <= cpol;
            spi_cs_n  <= ~cs_dec;
            if (cpha) begin
              spi_mosi     <= 1'b0;
              tx_shift_reg <= tx_data;
            end else begin
              // Leading-edge sampling needs the MSB on the line before edge 1.
              spi_mosi     <= tx_data[DATA_W-1];
              tx_shift_reg <= {tx_data[DATA_W-2:0], 1'b0};
            end
          end
        end
        SETUP, XFER: begin
          if (!period_end) begin
            cnt_reg <= cnt_reg + 1'b1;
          end else begin
            cnt_reg <= '0;
            if (half_reg == LAST_HALF) begin
              state_reg <= HOLD;
            end else begin
              state_reg <= XFER;
              half_reg  <= next_half;
              spi_clk   <= ~spi_clk;
              if (present_bit) begin
                spi_mosi     <= tx_shift_reg[DATA_W-1];
                tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
              end
              if (sample_bit) begin
                rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], spi_miso};
              end
            end
          end
        end
        HOLD: begin
          if (!period_end) begin
            cnt_reg <= cnt_reg + 1'b1;
          end else begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            rx_data   <= rx_shift_reg;
            spi_clk   <= cpol_reg;
            spi_mosi  <= 1'b0;
            spi_cs_n  <= '1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus pushes the expected outcome of
// each transfer, a behavioural SPI slave exchanges bits on the wire, and a
// monitor pops and compares whenever done pulses.
module tb_spi_master;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 8;
  localparam int NUM_CS = 2;
  localparam int CS_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic [CS_W-1:0]   cs_sel = '0;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
  logic [DIV_W-1:0]  clk_div = '0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_miso;
  logic [NUM_CS-1:0] spi_cs_n;

  spi_master #(
    .DATA_W(DATA_W), .DIV_W(DIV_W), .NUM_CS(NUM_CS), .CS_W(CS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
    .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
    .busy(busy), .done(done), .rx_data(rx_data), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] rx;
    logic [CS_W-1:0]   cs;
    int                busy_len;
    int                gap;
  } exp_t;

  exp_t exp_q[$];

  // Slave configuration, set by stimulus before each transfer.
  logic              loop_en = 1'b1;
  logic [DATA_W-1:0] cur_slave = '0;
  logic              cur_cpol = 1'b0;
  logic              cur_cpha = 1'b0;

  // Behavioural slave state.
  logic              slave_miso = 1'b0;
  logic [DATA_W-1:0] sl_shift = '0;
  logic [DATA_W-1:0] mosi_cap = '0;
  int                edge_cnt = 0;
  logic              busy_prev = 1'b0;
  logic              clk_prev = 1'b0;

  assign spi_miso = loop_en ? spi_mosi : slave_miso;

  // SPI slave: reacts to serial-clock edges, samples MOSI on its sampling
  // edge and shifts its reply out on the opposite edge.
  initial begin
    logic leading;
    forever begin
      @(spi_clk or busy);
      if (busy && !busy_prev) begin
        edge_cnt = 0;
        mosi_cap = '0;
        sl_shift = cur_slave;
        if (!cur_cpha) begin
          slave_miso = sl_shift[DATA_W-1];
          sl_shift   = sl_shift << 1;
        end
      end
      if (busy && (spi_clk !== clk_prev) &&
          ((spi_clk != cur_cpol) || (edge_cnt[0] == 1'b1))) begin
        edge_cnt = edge_cnt + 1;
        leading  = edge_cnt[0];
        if (cur_cpha ? !leading : leading) begin
          mosi_cap = {mosi_cap[DATA_W-2:0], spi_mosi};
        end else begin
          slave_miso = sl_shift[DATA_W-1];
          sl_shift   = sl_shift << 1;
        end
      end
      busy_prev = busy;
      clk_prev  = spi_clk;
    end
  end

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   wait_cnt = 0;
  int   last_done = -1000;
  int   xfer_num = 0;
  logic cs_bad = 1'b0;
  int   rst_req = 1;
  int   rst_seen = 0;

  function automatic void chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endfunction

  // Monitor: sampled on the falling edge, away from the active clock edge.
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] exp_cs;
    cyc = cyc + 1;
    if (!rst_n) begin
      exp_q.delete();
      busy_cnt = 0;
      wait_cnt = 0;
      cs_bad   = 1'b0;
      if (rst_req != rst_seen) begin
        rst_seen = rst_req;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_mosi", int'(spi_mosi), 0);
        chk("rst_spi_clk", int'(spi_clk), 0);
        chk("rst_cs_n", int'(spi_cs_n), 3);
      end
    end else begin
      if (busy) busy_cnt = busy_cnt + 1;
      if (busy && exp_q.size() > 0) begin
        exp_cs = 2'b11;
        if (exp_q[0].cs < 2) exp_cs[exp_q[0].cs[0]] = 1'b0;
        if (spi_cs_n !== exp_cs) cs_bad = 1'b1;
      end
      if (!busy && spi_cs_n !== 2'b11) cs_bad = 1'b1;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          xfer_num = xfer_num + 1;
          $display("xfer %0d: tx=%02h cs=%0d rx=%02h model=%02h busy=%0d model=%0d",
                   xfer_num, e.tx, e.cs, rx_data, e.rx, busy_cnt, e.busy_len);
          chk("rx_data", int'(rx_data), int'(e.rx));
          chk("busy_len", busy_cnt, e.busy_len);
          chk("clk_edges", edge_cnt, 2 * DATA_W);
          chk("mosi_bits", int'(mosi_cap), int'(e.tx));
          chk("cs_n_window", int'(cs_bad), 0);
          if (e.gap > 0) chk("done_gap", cyc - last_done, e.gap);
        end
        busy_cnt  = 0;
        cs_bad    = 1'b0;
        wait_cnt  = 0;
        last_done = cyc;
      end else if (exp_q.size() > 0) begin
        wait_cnt = wait_cnt + 1;
        if (wait_cnt > 6000) begin
          chk("done_timeout", wait_cnt, 0);
          exp_q.delete();
          wait_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic [7:0] tx, input logic [1:0] cs,
                       input logic pol, input logic pha, input logic [7:0] div,
                       input logic loop, input logic [7:0] slv, input int gap);
    exp_t e;
    cur_cpol  = pol;
    cur_cpha  = pha;
    loop_en   = loop;
    cur_slave = slv;
    tx_data   = tx;
    cs_sel    = cs;
    cpol      = pol;
    cpha      = pha;
    clk_div   = div;
    start     = 1'b1;
    e.tx       = tx;
    e.rx       = loop ? tx : slv;
    e.cs       = cs;
    e.busy_len = (2 * DATA_W + 2) * (int'(div) + 1);
    e.gap      = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 7000 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic [7:0] tx, input logic [1:0] cs,
                     input logic pol, input logic pha, input logic [7:0] div,
                     input logic loop, input logic [7:0] slv);
    @(negedge clk);
    issue(tx, cs, pol, pha, div, loop, slv, 0);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0 loopback, fastest clock.
    run(8'hA5, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h00);
    // Mode 3, divider 3, slave reply.
    run(8'h81, 2'd0, 1'b1, 1'b1, 8'd3, 1'b0, 8'h3C);
    // Mode 1 and mode 2.
    run(8'h5A, 2'd0, 1'b0, 1'b1, 8'd1, 1'b0, 8'hC3);
    run(8'h5A, 2'd1, 1'b1, 1'b0, 8'd1, 1'b0, 8'hC3);

    // cs 1, with a start pulse mid-transfer that must be ignored.
    @(negedge clk);
    issue(8'h37, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 8'h6E, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    cs_sel  = 2'd0;
    tx_data = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Out-of-range chip select: normal timing, no cs asserted.
    run(8'h4B, 2'd2, 1'b0, 1'b0, 8'd0, 1'b1, 8'h00);

    // Back-to-back with start held high across done.
    @(negedge clk);
    issue(8'h11, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h00, 0);
    @(negedge clk);
    tx_data = 8'h22;
    begin
      exp_t e2;
      e2.tx = 8'h22; e2.rx = 8'h22; e2.cs = 2'd0;
      e2.busy_len = (2 * DATA_W + 2); e2.gap = 2 * DATA_W + 3;
      exp_q.push_back(e2);
    end
    for (int i = 0; i < 200 && exp_q.size() > 1; i++) @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset in the middle of a transfer, then a clean transfer.
    @(negedge clk);
    issue(8'h3C, 2'd1, 1'b0, 1'b0, 8'd0, 1'b1, 8'h00, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    rst_req = rst_req + 1;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run(8'h96, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h00);

    // Widest divider value.
    run(8'hE7, 2'd1, 1'b1, 1'b0, 8'hFF, 1'b0, 8'h2D);

    // Randomised transfers.
    for (int i = 0; i < 20; i++) begin
      run(8'($urandom), 2'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
          8'($urandom_range(0, 3)), 1'($urandom), 8'($urandom));
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
